// File: rtl/rad_async_fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: read pointer (binary/Gray), empty flag,
// fill level, and a one-word prefetch register presented as a valid/ready stream.
module rad_async_fifo_rd_ctrl #(
  parameter int DSIZE    = 8,
  parameter int ADDRSIZE = 3
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic [DSIZE-1:0]    mem_rdata,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic [DSIZE-1:0]    rdata,
  output logic                rvalid,
  input  logic                rready,
  output logic [ADDRSIZE:0]   rlevel
);
  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] rbin, rbin_next, rgray_next, wbin;
  logic          rinc;

  // Fetch whenever a word is visible and the output register is free or being drained.
  assign rinc       = !rempty && (!rvalid || rready);
  assign rbin_next  = rbin + PW'(rinc);
  assign rgray_next = (rbin_next >> 1) ^ rbin_next;
  assign raddr      = rbin[ADDRSIZE-1:0];

  // Gray to binary: each bit is the XOR of itself and all higher Gray bits.
  for (genvar g = 0; g < PW; g++) begin : g_g2b
    assign wbin[g] = ^rq2_wptr[PW-1:g];
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin   <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
      rlevel <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rbin   <= rbin_next;
      rptr   <= rgray_next;
      rempty <= (rgray_next == rq2_wptr);
      rlevel <= wbin - rbin_next;
      if (rinc) begin
        rdata  <= mem_rdata;
        rvalid <= 1'b1;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end
endmodule
